// File: rtl/leaf_port_buffer.sv
`default_nettype none
// ============================================================================
// Module   : leaf_port_buffer
// Brief    : Per-port FWFT elastic buffers between leaf interface and kernel,
//            with outbound hold and per-channel transfer counters.
// Revision : 1.0
// ============================================================================

module leaf_port_buffer_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                vld_mask_i,
    input  logic [WIDTH-1:0]    up_data_i,
    input  logic                up_vld_i,
    output logic                up_ack_o,
    output logic [WIDTH-1:0]    dn_data_o,
    output logic                dn_vld_o,
    input  logic                dn_ack_i,
    output logic [CNT_BITS-1:0] count_o
);
    localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         occ_q, occ_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                w_push;
    logic                w_pop;

    // Handshake outputs depend only on registered occupancy, never on dn_ack_i.
    assign up_ack_o  = (occ_q != C_FULL) && !reset_i;
    assign dn_vld_o  = (occ_q != '0) && !reset_i && !vld_mask_i;
    assign w_push    = up_vld_i && up_ack_o;
    assign w_pop     = dn_vld_o && dn_ack_i;
    assign dn_data_o = dn_vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o   = reset_i ? '0 : cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once occupancy clears.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= up_data_i;
        end
    end
endmodule

module leaf_port_buffer #(
    parameter int NUM_IN_PORTS  = 3,
    parameter int NUM_OUT_PORTS = 3,
    parameter int PAYLOAD_BITS  = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_BITS      = 16
) (
    input  logic                                  clk_user,
    input  logic                                  reset,
    input  logic                                  hold,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_buf2user,
    output logic [NUM_IN_PORTS-1:0]               vld_buf2user,
    input  logic [NUM_IN_PORTS-1:0]               ack_user2buf,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user2buf,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user2buf,
    output logic [NUM_OUT_PORTS-1:0]              ack_buf2user,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]      in_count,
    output logic [NUM_OUT_PORTS*CNT_BITS-1:0]     out_count
);
    for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
        leaf_port_buffer_fifo #(
            .WIDTH    (PAYLOAD_BITS),
            .DEPTH    (FIFO_DEPTH),
            .CNT_BITS (CNT_BITS)
        ) u_fifo (
            .clk_i      (clk_user),
            .reset_i    (reset),
            .vld_mask_i (1'b0),
            .up_data_i  (dout_leaf_interface2user[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .up_vld_i   (vld_interface2user[k]),
            .up_ack_o   (ack_user2interface[k]),
            .dn_data_o  (dout_buf2user[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .dn_vld_o   (vld_buf2user[k]),
            .dn_ack_i   (ack_user2buf[k]),
            .count_o    (in_count[k*CNT_BITS +: CNT_BITS])
        );
    end

    // Hold masks interface-side valid, which also suppresses outbound pops.
    for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
        leaf_port_buffer_fifo #(
            .WIDTH    (PAYLOAD_BITS),
            .DEPTH    (FIFO_DEPTH),
            .CNT_BITS (CNT_BITS)
        ) u_fifo (
            .clk_i      (clk_user),
            .reset_i    (reset),
            .vld_mask_i (hold),
            .up_data_i  (din_user2buf[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .up_vld_i   (vld_user2buf[k]),
            .up_ack_o   (ack_buf2user[k]),
            .dn_data_o  (din_leaf_user2interface[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .dn_vld_o   (vld_user2interface[k]),
            .dn_ack_i   (ack_interface2user[k]),
            .count_o    (out_count[k*CNT_BITS +: CNT_BITS])
        );
    end
endmodule
`default_nettype wire

// File: doc/leaf_port_buffer.md
# leaf_port_buffer

Parametrised, per-port elastic buffer between the leaf interface and the user kernel inside a PR leaf shell. It replaces the fixed 3-in/3-out direct wiring with NUM_IN_PORTS inbound and NUM_OUT_PORTS outbound FIFOs, so user kernels of any port count can absorb stalls without backpressuring the BFT every cycle. It adds a `hold` mode that freezes traffic toward the interface during resend, and per-port transfer counters for debug.

## Interface
- NUM_IN_PORTS, 3: inbound (interface→user) channels, 1..15
- NUM_OUT_PORTS, 3: outbound (user→interface) channels, 1..15
- PAYLOAD_BITS, 32: data width per channel
- FIFO_DEPTH, 4: entries per channel; power of two, ≥2
- CNT_BITS, 16: width of each transfer counter

- clk_user  in  1  user clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- hold  in  1  freeze outbound toward interface (driven from `resend`)
- dout_leaf_interface2user  in  NUM_IN_PORTS*PAYLOAD_BITS  inbound data, channel k at [k*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_interface2user  in  NUM_IN_PORTS  inbound valid
- ack_user2interface  out  NUM_IN_PORTS  inbound accept toward interface
- dout_buf2user  out  NUM_IN_PORTS*PAYLOAD_BITS  data to kernel
- vld_buf2user  out  NUM_IN_PORTS  valid to kernel
- ack_user2buf  in  NUM_IN_PORTS  kernel accept
- din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS  outbound data to interface
- vld_user2interface  out  NUM_OUT_PORTS  outbound valid
- ack_interface2user  in  NUM_OUT_PORTS  interface accept
- din_user2buf  in  NUM_OUT_PORTS*PAYLOAD_BITS  kernel outbound data
- vld_user2buf  in  NUM_OUT_PORTS  kernel outbound valid
- ack_buf2user  out  NUM_OUT_PORTS  accept toward kernel
- in_count  out  NUM_IN_PORTS*CNT_BITS  words delivered to kernel, per channel
- out_count  out  NUM_OUT_PORTS*CNT_BITS  words delivered to interface, per channel

## Operation
- Handshake everywhere: word transfers on a cycle where vld && ack; vld must not depend on ack.
- Each channel: independent FWFT FIFO, FIFO_DEPTH entries; rd/wr pointers clog2(FIFO_DEPTH) bits, wrap naturally; occupancy clog2(FIFO_DEPTH)+1 bits.
- Push: upstream vld && ack; write at wr_ptr, wr_ptr+1.
- Pop: downstream vld && ack; rd_ptr+1.
- Upstream ack = (occ != FIFO_DEPTH) && !reset; from registers only, no comb path from downstream ack.
- Downstream vld = (occ != 0); data = head entry when vld, forced 0 when vld=0.
- Simultaneous push/pop: occ unchanged, both pointers advance; legal at any occ 1..FIFO_DEPTH-1. Full: ack=0, push impossible; pop allowed. Empty: no bypass; pushed word visible next cycle.
- hold=1: all vld_user2interface forced 0, outbound pops suppressed, contents retained; outbound pushes from kernel continue until full. Inbound channels unaffected.
- Counters: +1 per pop on that channel; wrap modulo 2^CNT_BITS.
- Reset (any time, incl. mid-transfer): pointers, occ, counters cleared; buffered words discarded; transfers in reset cycle ignored.

## Timing
- Reset values (cycle reset is high and after): every vld 0, every ack 0 during reset, every dout/din output 0, counters 0. First cycle after reset: all acks 1.
- Latency push→downstream vld: 1 cycle. Throughput: 1 word/cycle/channel sustained.
- hold rising: vld_user2interface 0 same cycle (comb mask). hold falling: vld reasserts same cycle if occ>0.
- Counter updates visible cycle after pop.
- Full recovery: pop at cycle t → ack=1 at t+1.

## Test plan
- Reset mid-stream: channel 0 holding 3 words, assert reset 1 cycle → vld_buf2user=0, in_count=0, ack_user2interface all 1 next cycle, old words never appear.
- Streaming: push 0x0..0x63 into inbound ch2 with ack_user2buf=1 → same order out, 1-cycle latency, no bubbles, in_count[2]=100.
- Full/backpressure: ack_user2buf[1]=0, push 4 words (depth 4) → ack_user2interface[1]=0 after 4th; release → words A,B,C,D out, ack returns cycle after first pop.
- Hold: 2 words queued on out ch0, hold=1 for 10 cycles with ack_interface2user=1 → vld_user2interface[0]=0, out_count[0]=0; hold=0 → both words drain, out_count[0]=2.
- Simultaneous push/pop at occ=2 for 20 cycles → occ stays 2, data order preserved, counter wraps from 0xFFFF to 0 with CNT_BITS=16 after preload of 65535 pops.
- Channel independence: NUM_IN_PORTS=5, NUM_OUT_PORTS=1, random vld/ack per channel → each channel's scoreboard matches, no cross-channel data.
